// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: byte-addressed instruction memory, instruction decode,
// next-PC prediction, and the F and D pipeline registers.
module fetch_stage #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       PC_new,
    input  logic              F_stall,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [7:0]        imem_wdata,
    output logic [63:0]       F_predPC,
    output logic [2:0]        D_stat,
    output logic [3:0]        D_icode,
    output logic [3:0]        D_ifun,
    output logic [3:0]        D_rA,
    output logic [3:0]        D_rB,
    output logic [63:0]       D_valC,
    output logic [63:0]       D_valP
);

    localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);
    localparam logic [2:0]  STAT_AOK  = 3'd1;
    localparam logic [2:0]  STAT_HLT  = 3'd2;
    localparam logic [2:0]  STAT_ADR  = 3'd3;
    localparam logic [2:0]  STAT_INS  = 3'd4;
    localparam logic [3:0]  REG_NONE  = 4'hF;

    logic [7:0]  imem_q [MEM_BYTES];
    logic [63:0] byte_addr [10];
    logic [7:0]  ibyte [10];

    logic [3:0]  icode, ifun, f_ra, f_rb;
    logic [63:0] f_valc, f_valp, pred_pc, last_addr, ilen;
    logic [2:0]  f_stat;
    logic        instr_valid, need_regids, valc_at_2, valc_at_1;

    logic [63:0] f_pred_pc_q, f_pred_pc_d;
    logic [2:0]  d_stat_q, d_stat_d;
    logic [3:0]  d_icode_q, d_icode_d, d_ifun_q, d_ifun_d;
    logic [3:0]  d_ra_q, d_ra_d, d_rb_q, d_rb_d;
    logic [63:0] d_valc_q, d_valc_d, d_valp_q, d_valp_d;

    // Load port ignores reset so a program can be preloaded while held in reset.
    always_ff @(posedge clk) begin
        if (imem_we && (64'(imem_waddr) < MEM_LIMIT)) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < 10; i++) begin
            byte_addr[i] = PC_new + 64'(i);
            ibyte[i]     = 8'h00;
            if (byte_addr[i] < MEM_LIMIT) begin
                ibyte[i] = imem_q[byte_addr[i][ADDR_W-1:0]];
            end
        end
    end

    always_comb begin
        icode = ibyte[0][7:4];
        ifun  = ibyte[0][3:0];

        unique case (icode)
            4'h2, 4'h7: instr_valid = (ifun <= 4'd6);
            4'h6:       instr_valid = (ifun <= 4'd3);
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                        instr_valid = (ifun == 4'd0);
            default:    instr_valid = 1'b0;
        endcase

        need_regids = instr_valid && (icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
        valc_at_2   = instr_valid && (icode inside {4'h3, 4'h4, 4'h5});
        valc_at_1   = instr_valid && (icode inside {4'h7, 4'h8});

        ilen = 64'd1;
        if (valc_at_2)        ilen = 64'd10;
        else if (valc_at_1)   ilen = 64'd9;
        else if (need_regids) ilen = 64'd2;

        f_ra = need_regids ? ibyte[1][7:4] : REG_NONE;
        f_rb = need_regids ? ibyte[1][3:0] : REG_NONE;

        f_valc = 64'd0;
        if (valc_at_2) begin
            f_valc = {ibyte[9], ibyte[8], ibyte[7], ibyte[6],
                      ibyte[5], ibyte[4], ibyte[3], ibyte[2]};
        end else if (valc_at_1) begin
            f_valc = {ibyte[8], ibyte[7], ibyte[6], ibyte[5],
                      ibyte[4], ibyte[3], ibyte[2], ibyte[1]};
        end

        f_valp    = PC_new + ilen;
        last_addr = PC_new + ilen - 64'd1;

        // Address error outranks an illegal opcode.
        if ((PC_new >= MEM_LIMIT) || (last_addr >= MEM_LIMIT)) f_stat = STAT_ADR;
        else if (!instr_valid)                                  f_stat = STAT_INS;
        else if (icode == 4'h0)                                 f_stat = STAT_HLT;
        else                                                    f_stat = STAT_AOK;

        pred_pc = (icode == 4'h7 || icode == 4'h8) ? f_valc : f_valp;
    end

    always_comb begin
        f_pred_pc_d = F_stall ? f_pred_pc_q : pred_pc;

        d_stat_d  = d_stat_q;
        d_icode_d = d_icode_q;
        d_ifun_d  = d_ifun_q;
        d_ra_d    = d_ra_q;
        d_rb_d    = d_rb_q;
        d_valc_d  = d_valc_q;
        d_valp_d  = d_valp_q;
        if (!D_stall) begin
            if (D_bubble) begin
                d_stat_d  = STAT_AOK;
                d_icode_d = 4'h1;
                d_ifun_d  = 4'h0;
                d_ra_d    = REG_NONE;
                d_rb_d    = REG_NONE;
                d_valc_d  = 64'd0;
                d_valp_d  = 64'd0;
            end else begin
                d_stat_d  = f_stat;
                d_icode_d = icode;
                d_ifun_d  = ifun;
                d_ra_d    = f_ra;
                d_rb_d    = f_rb;
                d_valc_d  = f_valc;
                d_valp_d  = f_valp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_pred_pc_q <= 64'd0;
            d_stat_q    <= STAT_AOK;
            d_icode_q   <= 4'h1;
            d_ifun_q    <= 4'h0;
            d_ra_q      <= REG_NONE;
            d_rb_q      <= REG_NONE;
            d_valc_q    <= 64'd0;
            d_valp_q    <= 64'd0;
        end else begin
            f_pred_pc_q <= f_pred_pc_d;
            d_stat_q    <= d_stat_d;
            d_icode_q   <= d_icode_d;
            d_ifun_q    <= d_ifun_d;
            d_ra_q      <= d_ra_d;
            d_rb_q      <= d_rb_d;
            d_valc_q    <= d_valc_d;
            d_valp_q    <= d_valp_d;
        end
    end

    assign F_predPC = f_pred_pc_q;
    assign D_stat   = d_stat_q;
    assign D_icode  = d_icode_q;
    assign D_ifun   = d_ifun_q;
    assign D_rA     = d_ra_q;
    assign D_rB     = d_rb_q;
    assign D_valC   = d_valc_q;
    assign D_valP   = d_valp_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: preloads a small program during reset,
// then fetches from chosen addresses and checks the F/D registers.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] PC_new;
  logic        F_stall, D_stall, D_bubble;
  logic        imem_we;
  logic [9:0]  imem_waddr;
  logic [7:0]  imem_wdata;
  logic [63:0] F_predPC, D_valC, D_valP;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.MEM_BYTES(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .PC_new(PC_new),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .F_predPC(F_predPC), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic write_byte(input logic [9:0] addr, input logic [7:0] data);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    step();
    imem_we    = 1'b0;
  endtask

  task automatic write_seq(input logic [9:0] base, input logic [7:0] b[$]);
    foreach (b[i]) write_byte(base + 10'(i), b[i]);
  endtask

  task automatic fetch(input logic [63:0] pc);
    PC_new = pc;
    step();
  endtask

  initial begin
    rst_n = 1'b0; PC_new = 64'h40;
    F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    step();
    step();

    // preload while in reset
    write_seq(10'h000, '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
    write_byte(10'h010, 8'h00);
    write_seq(10'h020, '{8'h70, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    write_seq(10'h030, '{8'h80, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    write_byte(10'h040, 8'h90);
    write_byte(10'h050, 8'hC0);
    write_seq(10'h060, '{8'h67, 8'h12});
    write_seq(10'h070, '{8'h60, 8'h12});
    write_byte(10'h080, 8'h10);
    write_byte(10'h3FB, 8'h30);
    write_byte(10'h3FF, 8'h10);

    check("rst_predpc", F_predPC, 64'h0);
    check("rst_icode", 64'(D_icode), 64'h1);
    check("rst_stat", 64'(D_stat), 64'h1);
    check("rst_ra", 64'(D_rA), 64'hF);
    check("rst_rb", 64'(D_rB), 64'hF);
    check("rst_valp", D_valP, 64'h0);

    rst_n = 1'b1;
    fetch(64'h40);
    check("ret_icode", 64'(D_icode), 64'h9);
    check("ret_valp", D_valP, 64'h41);
    check("ret_predpc", F_predPC, 64'h41);
    check("ret_ra", 64'(D_rA), 64'hF);

    fetch(64'h0);
    check("irm_icode", 64'(D_icode), 64'h3);
    check("irm_ra", 64'(D_rA), 64'hF);
    check("irm_rb", 64'(D_rB), 64'h3);
    check("irm_valc", D_valC, 64'h0102030405060708);
    check("irm_valp", D_valP, 64'd10);
    check("irm_predpc", F_predPC, 64'd10);
    check("irm_stat", 64'(D_stat), 64'h1);

    fetch(64'h20);
    check("jmp_valp", D_valP, 64'h29);
    check("jmp_valc", D_valC, 64'h100);
    check("jmp_predpc", F_predPC, 64'h100);

    fetch(64'h30);
    check("call_icode", 64'(D_icode), 64'h8);
    check("call_valp", D_valP, 64'h39);
    check("call_predpc", F_predPC, 64'h200);

    fetch(64'h10);
    check("hlt_stat", 64'(D_stat), 64'h2);
    check("hlt_icode", 64'(D_icode), 64'h0);
    check("hlt_predpc", F_predPC, 64'h11);

    fetch(64'h50);
    check("badic_stat", 64'(D_stat), 64'h4);
    check("badic_valp", D_valP, 64'h51);
    check("badic_rb", 64'(D_rB), 64'hF);

    fetch(64'h60);
    check("badfn_stat", 64'(D_stat), 64'h4);
    check("badfn_valp", D_valP, 64'h61);
    check("badfn_ra", 64'(D_rA), 64'hF);

    fetch(64'h3FB);
    check("adr_end_stat", 64'(D_stat), 64'h3);

    fetch(64'hFFFF_FFFF_FFFF_FFFF);
    check("adr_max_stat", 64'(D_stat), 64'h3);

    fetch(64'h3FF);
    check("last_stat", 64'(D_stat), 64'h1);
    check("last_valp", D_valP, 64'h400);

    // fetch of a byte written in the same cycle sees the old value
    PC_new = 64'h80; imem_we = 1'b1; imem_waddr = 10'h080; imem_wdata = 8'h00;
    step();
    imem_we = 1'b0;
    check("rw_old_icode", 64'(D_icode), 64'h1);
    fetch(64'h80);
    check("rw_new_icode", 64'(D_icode), 64'h0);
    check("rw_new_stat", 64'(D_stat), 64'h2);

    fetch(64'h70);
    check("opq_icode", 64'(D_icode), 64'h6);
    check("opq_ra", 64'(D_rA), 64'h1);
    check("opq_rb", 64'(D_rB), 64'h2);
    check("opq_predpc", F_predPC, 64'h72);

    F_stall = 1'b1; D_stall = 1'b1; PC_new = 64'h0;
    step();
    step();
    check("stall_predpc", F_predPC, 64'h72);
    check("stall_icode", 64'(D_icode), 64'h6);
    check("stall_valp", D_valP, 64'h72);

    F_stall = 1'b0; D_stall = 1'b1; D_bubble = 1'b1; PC_new = 64'h20;
    step();
    check("stbub_icode", 64'(D_icode), 64'h6);
    check("stbub_predpc", F_predPC, 64'h100);

    D_stall = 1'b0; D_bubble = 1'b1; PC_new = 64'h0;
    step();
    check("bub_icode", 64'(D_icode), 64'h1);
    check("bub_stat", 64'(D_stat), 64'h1);
    check("bub_rb", 64'(D_rB), 64'hF);
    check("bub_predpc", F_predPC, 64'd10);
    D_bubble = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
